reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the datapath labs.
- Next generation of the single-read/single-write 8x16 file: configurable width and depth, two independent read ports, one write port.
- Adds write-to-read bypass and a per-register busy scoreboard so a pipelined core can detect pending writebacks.
- All state and outputs are updated on the rising edge of one clock.

Parameters:
- Width, 16, data bits per register.
- Depth, 8, number of registers; power of two, at least 2.
- AddrW, 3, address bits; must equal log2(Depth).

Ports:
- clk  in  1  clock; all activity on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- read_enable0  in  1  read request, port 0.
- read_addr0  in  AddrW  read address, port 0.
- read_data0  out  Width  registered read data, port 0.
- read_valid0  out  1  read_data0/read_busy0 hold a result from the previous cycle's request.
- read_busy0  out  1  scoreboard bit of the register read, port 0.
- read_enable1, read_addr1, read_data1, read_valid1, read_busy1: identical set for port 1.
- write_enable  in  1  write request.
- write_addr  in  AddrW  write address.
- write_data  in  Width  write data.
- rsv_enable  in  1  reserve request: mark a register busy (pending writeback).
- rsv_addr  in  AddrW  register to reserve.

Behaviour:
- Reset: when rst=1 at a rising edge:
  - every register clears to 0 and every busy bit clears to 0;
  - read_data0/1 = 0, read_valid0/1 = 0, read_busy0/1 = 0;
  - write and reserve requests in that cycle are ignored.
  - Reset asserted mid-stream discards any pending read result; the first read after reset returns 0 with busy = 0.
- Write: write_enable=1 at an edge stores write_data into reg[write_addr] and clears busy[write_addr]. The stored value is visible to requests from the next cycle on.
- Read latency: exactly 1 cycle.
  - A request sampled with read_enable=1 at edge N drives read_data/read_busy and read_valid=1 after edge N.
  - With read_enable=0, read_valid=0 after the edge; read_data and read_busy hold their previous values (no tri-state).
- Bypass: if read_enable=1, write_enable=1 and read_addr==write_addr in the same cycle:
  - read_data returns write_data (new value), not the old contents;
  - read_busy returns 0, because the write clears the bit.
  - This applies to each port independently; both ports may bypass in the same cycle.
- Same-address reads: both ports may read the same address in the same cycle; both return the same value.
- Reserve: rsv_enable=1 sets busy[rsv_addr] at the edge.
  - A reservation is not visible to reads issued in the same cycle; it is visible from the next cycle.
  - Write and reserve to the same address in the same cycle: data is written and busy ends at 1 (reserve wins; models back-to-back producers).
  - Write and reserve to different addresses: both take effect.
- Address wrap: addresses are exactly AddrW bits, so no out-of-range case exists when Depth = 2^AddrW.
- No state machine beyond the register and busy arrays and the output registers; no back-pressure; every request completes.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - reg[0] reads as 0 on both ports at all times;
  - writes to address 0 are discarded, including the bypass path (bypassed value is 0);
  - busy[0] is never set, and reservations of address 0 are ignored.
- Undefined: address 0 is an ordinary register.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then read_enable0=1, addr 5 -> after 1 edge read_data0=0x0000, read_valid0=1, read_busy0=0.
- Write/read latency: write 0xBEEF to addr 3 at edge N; port1 reads addr 3 at edge N+1 -> read_data1=0xBEEF after N+1, read_valid1=1.
- Bypass: in one cycle write 0x1234 to addr 6 while both ports read addr 6 -> both ports return 0x1234, busy=0, after one edge.
- Scoreboard: reserve addr 2 at edge N; read addr 2 at N+1 -> read_busy0=1. Write 0x00AA to addr 2 plus reserve addr 2 in the same cycle -> a later read gives busy=1 and data 0x00AA. A plain write then clears busy to 0.
- Mid-operation reset: write 0xFFFF to addr 7, issue a read, assert rst on the next edge -> read_valid0=0, read_data0=0. A later read of addr 7 returns 0.
- With RF_ZERO_REG_EN: write 0x5555 to addr 0 with a same-cycle read of addr 0 -> returns 0; a later read returns 0; a reserve of addr 0 leaves busy=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: two registered read ports, one write port, write-to-read
// bypass and a per-register busy scoreboard. Optional macro RF_ZERO_REG_EN hardwires reg[0] to zero.
module reg_file_mp #(
  parameter int Width = 16,
  parameter int Depth = 8,
  parameter int AddrW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_enable0,
  input  logic [AddrW-1:0] read_addr0,
  output logic [Width-1:0] read_data0,
  output logic             read_valid0,
  output logic             read_busy0,
  input  logic             read_enable1,
  input  logic [AddrW-1:0] read_addr1,
  output logic [Width-1:0] read_data1,
  output logic             read_valid1,
  output logic             read_busy1,
  input  logic             write_enable,
  input  logic [AddrW-1:0] write_addr,
  input  logic [Width-1:0] write_data,
  input  logic             rsv_enable,
  input  logic [AddrW-1:0] rsv_addr
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [Width-1:0] regs [Depth];
  logic [Depth-1:0] busy;

  logic             write_ok;
  logic             rsv_ok;
  logic [Width-1:0] next_data0, next_data1;
  logic             next_busy0, next_busy1;

  assign write_ok = write_enable && !(ZeroReg && (write_addr == '0));
  assign rsv_ok   = rsv_enable && !(ZeroReg && (rsv_addr == '0));

  // Read value seen by each port: zero register, then bypass, then stored contents.
  always_comb begin
    next_data0 = regs[read_addr0];
    next_busy0 = busy[read_addr0];
    if (ZeroReg && (read_addr0 == '0)) begin
      next_data0 = '0;
      next_busy0 = 1'b0;
    end else if (write_enable && (write_addr == read_addr0)) begin
      next_data0 = write_data;
      next_busy0 = 1'b0;
    end
  end

  always_comb begin
    next_data1 = regs[read_addr1];
    next_busy1 = busy[read_addr1];
    if (ZeroReg && (read_addr1 == '0)) begin
      next_data1 = '0;
      next_busy1 = 1'b0;
    end else if (write_enable && (write_addr == read_addr1)) begin
      next_data1 = write_data;
      next_busy1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) regs[i] <= '0;
      busy        <= '0;
      read_data0  <= '0;
      read_valid0 <= 1'b0;
      read_busy0  <= 1'b0;
      read_data1  <= '0;
      read_valid1 <= 1'b0;
      read_busy1  <= 1'b0;
    end else begin
      if (write_ok) begin
        regs[write_addr] <= write_data;
        busy[write_addr] <= 1'b0;
      end
      // Reserve is applied last so it wins over a same-address write.
      if (rsv_ok) busy[rsv_addr] <= 1'b1;

      read_valid0 <= read_enable0;
      if (read_enable0) begin
        read_data0 <= next_data0;
        read_busy0 <= next_busy0;
      end
      read_valid1 <= read_enable1;
      if (read_enable1) begin
        read_data1 <= next_data1;
        read_busy1 <= next_busy1;
      end
    end
  end

endmodule
